// File: rtl/eth_pcs_pkg.sv
// Shared types and constants for the 64b/66b PCS receive path.
package eth_pcs_pkg;

  // Block-lock FSM states
  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    RESET_CNT = 2'd1,
    TEST_SH   = 2'd2,
    SLIP      = 2'd3
  } bl_fsm_t;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // A sync header is valid only if its two bits differ in one of the two legal ways
  function automatic logic sh_is_valid(input logic [1:0] hdr);
    return (hdr == SH_DATA) || (hdr == SH_CTRL);
  endfunction

endpackage

// File: rtl/eth_block_sync_lane.sv
// One lane of the 64b/66b block synchroniser: lock FSM, header counters,
// slip request, saturating slip statistics and lock-loss pulse.
module eth_block_sync_lane
  import eth_pcs_pkg::*;
#(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 4,
  parameter int SLIP_CNT_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_header,
  input  logic                  i_header_valid,
  input  logic                  i_stat_clr,
  output logic                  o_block_lock,
  output logic                  o_rxslip,
  output logic                  o_lock_lost,
  output logic [SLIP_CNT_W-1:0] o_slip_count
);

  localparam int CW = $clog2(SH_CNT_MAX + 1);
  localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SH_CNT_MAX);
  localparam logic [CW-1:0] INV_MAX   = CW'(SH_INVALID_MAX);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(SLIP_WAIT - 1);

  bl_fsm_t               state_q, state_d;
  logic                  lock_q, lock_d;
  logic [CW-1:0]         sh_cnt_q, sh_cnt_d;
  logic [CW-1:0]         sh_inv_q, sh_inv_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic                  rxslip_q, rxslip_d;
  logic                  lost_q;
  logic [SLIP_CNT_W-1:0] slip_cnt_q, slip_cnt_d;
  logic                  hdr_ok;
  logic [CW-1:0]         nc, ni;

  assign hdr_ok = sh_is_valid(i_header);
  assign nc     = sh_cnt_q + 1'b1;
  assign ni     = sh_inv_q + CW'(!hdr_ok);

  // Next-state logic: lock FSM, window counters and slip dwell timer
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    sh_cnt_d = sh_cnt_q;
    sh_inv_d = sh_inv_q;
    wait_d   = wait_q;
    rxslip_d = 1'b0;
    case (state_q)
      LOCK_INIT: begin
        lock_d  = 1'b0;
        state_d = RESET_CNT;
      end
      RESET_CNT: begin
        sh_cnt_d = '0;
        sh_inv_d = '0;
        state_d  = TEST_SH;
      end
      TEST_SH: begin
        if (i_header_valid) begin
          sh_cnt_d = nc;
          if (hdr_ok) begin
            if (nc == CNT_MAX) begin
              if (ni == '0) lock_d = 1'b1;
              state_d = RESET_CNT;
            end
          end else begin
            sh_inv_d = ni;
            // Slip wins over a window that happens to end on the same header
            if ((ni == INV_MAX) || !lock_q) begin
              state_d  = SLIP;
              lock_d   = 1'b0;
              rxslip_d = 1'b1;
              wait_d   = WAIT_LOAD;
            end else if (nc == CNT_MAX) begin
              state_d = RESET_CNT;
            end
          end
        end
      end
      SLIP: begin
        // Dwell is time-based so the GT has settled before headers are recounted
        if (wait_q == '0) state_d = RESET_CNT;
        else              wait_d  = wait_q - 1'b1;
      end
      default: begin
        state_d = LOCK_INIT;
        lock_d  = 1'b0;
      end
    endcase
  end

  // Slip statistic: counts the visible rxslip pulse, clear takes precedence but keeps a coincident slip
  always_comb begin
    slip_cnt_d = slip_cnt_q;
    if (i_stat_clr)
      slip_cnt_d = SLIP_CNT_W'(rxslip_q);
    else if (rxslip_q && !(&slip_cnt_q))
      slip_cnt_d = slip_cnt_q + 1'b1;
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= LOCK_INIT;
      lock_q     <= 1'b0;
      sh_cnt_q   <= '0;
      sh_inv_q   <= '0;
      wait_q     <= '0;
      rxslip_q   <= 1'b0;
      lost_q     <= 1'b0;
      slip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_inv_q   <= sh_inv_d;
      wait_q     <= wait_d;
      rxslip_q   <= rxslip_d;
      lost_q     <= lock_q & ~lock_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  assign o_block_lock = lock_q;
  assign o_rxslip     = rxslip_q;
  assign o_lock_lost  = lost_q;
  assign o_slip_count = slip_cnt_q;

endmodule

// File: rtl/eth_block_sync.sv
// Multi-lane 64b/66b block synchroniser: independent per-lane lock FSMs
// plus a registered all-lanes-locked flag.
module eth_block_sync
  import eth_pcs_pkg::*;
#(
  parameter int NUM_LANES      = 1,
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 4,
  parameter int SLIP_CNT_W     = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [2*NUM_LANES-1:0]          i_header,
  input  logic [NUM_LANES-1:0]            i_header_valid,
  input  logic                            i_stat_clr,
  output logic [NUM_LANES-1:0]            o_block_lock,
  output logic [NUM_LANES-1:0]            o_rxslip,
  output logic [NUM_LANES-1:0]            o_lock_lost,
  output logic [NUM_LANES*SLIP_CNT_W-1:0] o_slip_count,
  output logic                            o_all_locked
);

  logic [NUM_LANES-1:0] block_lock_w;
  logic                 all_locked_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      eth_block_sync_lane #(
        .SH_CNT_MAX     (SH_CNT_MAX),
        .SH_INVALID_MAX (SH_INVALID_MAX),
        .SLIP_WAIT      (SLIP_WAIT),
        .SLIP_CNT_W     (SLIP_CNT_W)
      ) u_lane (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_header       (i_header[2*gi +: 2]),
        .i_header_valid (i_header_valid[gi]),
        .i_stat_clr     (i_stat_clr),
        .o_block_lock   (block_lock_w[gi]),
        .o_rxslip       (o_rxslip[gi]),
        .o_lock_lost    (o_lock_lost[gi]),
        .o_slip_count   (o_slip_count[SLIP_CNT_W*gi +: SLIP_CNT_W])
      );
    end
  endgenerate

  // Aggregate lock flag, one cycle behind the per-lane flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) all_locked_q <= 1'b0;
    else          all_locked_q <= &block_lock_w;
  end

  assign o_block_lock = block_lock_w;
  assign o_all_locked = all_locked_q;

endmodule

// File: tb/tb_eth_block_sync.sv
// Self-checking bench for eth_block_sync: directed phase table, hand-written
// corner sequences and a randomized run against a behavioural lane model.
module tb_eth_block_sync;

  localparam int NL      = 4;
  localparam int SW      = 2;
  localparam int SH_MAX  = 64;
  localparam int INV_MAX = 16;
  localparam int SWAIT   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2*NL-1:0]   hdr = '0;
  logic [NL-1:0]     hv = '0;
  logic              clr = 1'b0;
  logic [NL-1:0]     lock, rxslip, lost;
  logic [NL*SW-1:0]  scnt;
  logic              all_locked;

  eth_block_sync #(
    .NUM_LANES      (NL),
    .SH_CNT_MAX     (SH_MAX),
    .SH_INVALID_MAX (INV_MAX),
    .SLIP_WAIT      (SWAIT),
    .SLIP_CNT_W     (SW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_header       (hdr),
    .i_header_valid (hv),
    .i_stat_clr     (clr),
    .o_block_lock   (lock),
    .o_rxslip       (rxslip),
    .o_lock_lost    (lost),
    .o_slip_count   (scnt),
    .o_all_locked   (all_locked)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: per lane, "gap" is the number of upcoming cycles in
  // which headers are not looked at (init, window restart, slip settle).
  bit m_lock[NL];
  int m_cnt[NL];
  int m_inv[NL];
  int m_gap[NL];
  int m_sc[NL];
  bit m_rx[NL];
  bit m_lost[NL];
  bit m_all;

  typedef struct {
    logic [1:0]  hdr;
    logic [3:0]  bad;
    bit          toggle;
    int          cycles;
    logic [3:0]  exp_lock;
    logic        exp_all;
    logic [3:0]  exp_lost;
    logic [7:0]  exp_cnt;
  } phase_t;

  phase_t tbl[4];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      m_lock[i] = 0; m_cnt[i] = 0; m_inv[i] = 0; m_gap[i] = 2;
      m_sc[i] = 0; m_rx[i] = 0; m_lost[i] = 0;
    end
    m_all = 0;
  endfunction

  function automatic logic [20:0] model_out();
    logic [NL-1:0]    l, r, o;
    logic [NL*SW-1:0] s;
    for (int i = 0; i < NL; i++) begin
      l[i] = m_lock[i];
      r[i] = m_rx[i];
      o[i] = m_lost[i];
      s[i*SW +: SW] = SW'(m_sc[i]);
    end
    return {m_all, l, r, o, s};
  endfunction

  // Advance model and DUT by one clock with the currently driven inputs
  task automatic step();
    bit nxt_all;
    nxt_all = 1;
    for (int i = 0; i < NL; i++) nxt_all &= m_lock[i];
    for (int i = 0; i < NL; i++) begin
      logic [1:0] h;
      bit         vh;
      h  = hdr[2*i +: 2];
      vh = (h == 2'b01) || (h == 2'b10);
      if (clr)                                    m_sc[i] = m_rx[i] ? 1 : 0;
      else if (m_rx[i] && m_sc[i] < (1 << SW) - 1) m_sc[i]++;
      m_rx[i] = 0;
      m_lost[i] = 0;
      if (m_gap[i] > 0) begin
        m_gap[i]--;
      end else if (hv[i]) begin
        m_cnt[i]++;
        if (!vh) m_inv[i]++;
        if (!vh && (m_inv[i] == INV_MAX || !m_lock[i])) begin
          m_lost[i] = m_lock[i];
          m_lock[i] = 0;
          m_rx[i]   = 1;
          m_gap[i]  = SWAIT + 1;
          m_cnt[i]  = 0;
          m_inv[i]  = 0;
        end else if (m_cnt[i] == SH_MAX) begin
          if (m_inv[i] == 0) m_lock[i] = 1;
          m_gap[i] = 1;
          m_cnt[i] = 0;
          m_inv[i] = 0;
        end
      end
    end
    m_all = nxt_all;
    @(posedge clk);
    #1;
    check("cycle", {all_locked, lock, rxslip, lost, scnt}, model_out());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    hv    = '0;
    hdr   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {all_locked, lock, rxslip, lost, scnt}, 21'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_all(logic [1:0] h);
    hv  = '1;
    hdr = {NL{h}};
  endtask

  initial begin
    int k;
    int pulses;
    int rate;

    tbl[0] = '{2'b01, 4'b0000, 1'b0, 67,  4'hF,    1'b1, 4'h0,    8'h00};
    tbl[1] = '{2'b01, 4'b0100, 1'b0, 16,  4'b1011, 1'b1, 4'b0100, 8'h00};
    tbl[2] = '{2'b01, 4'b0000, 1'b0, 1,   4'b1011, 1'b0, 4'h0,    8'h10};
    tbl[3] = '{2'b01, 4'b0000, 1'b1, 200, 4'hF,    1'b1, 4'h0,    8'h10};

    do_reset();

    // Directed phases: lock, single-lane corruption, aggregate drop, gapped relock
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < tbl[p].cycles; c++) begin
        hv = (tbl[p].toggle && (c % 2 == 1)) ? '0 : '1;
        for (int i = 0; i < NL; i++)
          hdr[2*i +: 2] = (!hv[i] || tbl[p].bad[i]) ? 2'b00 : tbl[p].hdr;
        step();
      end
      check($sformatf("phase%0d_lock", p), lock, tbl[p].exp_lock);
      check($sformatf("phase%0d_all", p), all_locked, tbl[p].exp_all);
      check($sformatf("phase%0d_lost", p), lost, tbl[p].exp_lost);
      check($sformatf("phase%0d_cnt", p), scnt, tbl[p].exp_cnt);
    end

    // Locked lane 0: 15 invalid in a window holds lock, 16th in next window slips
    k = 0;
    while (!(m_gap[0] == 0 && m_cnt[0] == 0) && k < 200) begin
      drive_all(2'b01);
      step();
      k++;
    end
    check("win_align_bound", k < 200, 1);
    for (int j = 0; j < 64; j++) begin
      drive_all(2'b01);
      if (j < 15) hdr[1:0] = 2'b00;
      step();
    end
    check("held_15_invalid", lock[0], 1);
    drive_all(2'b01);
    hdr[1:0] = 2'b00;  // lane 0 is restarting its window: must be ignored
    step();
    for (int j = 0; j <= 20; j++) begin
      drive_all(2'b01);
      if (j >= 5) hdr[1:0] = 2'b00;
      step();
      if (j == 19) check("lock_before_16th", lock[0], 1);
    end
    check("slip_16th_lock", lock[0], 0);
    check("slip_16th_lost", lost[0], 1);
    check("slip_16th_rxslip", rxslip, 4'b0001);
    check("other_lanes_locked", lock[3:1], 3'b111);
    drive_all(2'b01);
    repeat (80) step();
    check("relock_lane0", lock, 4'hF);

    // Unlocked lane 1 sees only invalid headers: slip timing, count, saturation, clear
    do_reset();
    drive_all(2'b01);
    hdr[3:2] = 2'b00;
    repeat (3) step();
    check("first_slip_pulse", rxslip, 4'b0010);
    step();
    check("slip_one_cycle", rxslip, 4'b0000);
    check("slip_count_1", scnt[3:2], 2'd1);
    pulses = 1;
    k = 0;
    while (pulses < 3 && k < 100) begin step(); if (m_rx[1]) pulses++; k++; end
    step();
    check("slip_count_3", scnt[3:2], 2'd3);
    k = 0;
    while (pulses < 5 && k < 100) begin step(); if (m_rx[1]) pulses++; k++; end
    step();
    check("slip_count_sat", scnt[3:2], 2'd3);
    k = 0;
    while (!m_rx[1] && k < 20) begin step(); k++; end
    check("slip_wait_bound", k < 20, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_with_slip", scnt[3:2], 2'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_alone", scnt[3:2], 2'd0);
    repeat (70) step();

    // Asynchronous reset while lane 1 is mid-SLIP and other lanes are locked
    k = 0;
    while (m_gap[1] != 3 && k < 20) begin step(); k++; end
    check("mid_slip_bound", k < 20, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {all_locked, lock, rxslip, lost, scnt}, 21'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_all(2'b01);
    repeat (67) step();
    check("relock_after_rst", {all_locked, lock}, 5'h1F);

    // Randomized run with per-segment error rates, gaps and occasional clears
    for (int seg = 0; seg < 8; seg++) begin
      rate = ($urandom_range(0, 1) == 0) ? 60 : 3;
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < NL; i++) begin
          hv[i] = ($urandom_range(0, 9) != 0);
          if ($urandom_range(0, rate - 1) == 0)
            hdr[2*i +: 2] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
          else
            hdr[2*i +: 2] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        end
        clr = ($urandom_range(0, 99) == 0);
        step();
      end
    end
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eth_block_sync.md
Name: eth_block_sync

Overview:
- Multi-lane, parametrised 64b/66b block synchroniser (IEEE 802.3 Cl.49 Fig 49-14 lock FSM), one independent lock FSM per lane.
- Sits between each lane's gearbox/GT RX output and the descrambler, and drives per-lane RXSLIP back to the transceiver.
- Adds the following to the single-lane lock FSM:
  - header-valid qualification for gearbox gaps
  - configurable window, threshold and slip settle time
  - per-lane saturating slip statistics and lock-loss pulses
  - an aggregate all-locked flag

Parameters:
NUM_LANES, 1, number of independent lanes (1..8)
SH_CNT_MAX, 64, sync headers per test window
SH_INVALID_MAX, 16, invalid headers in one window that force a slip while locked
SLIP_WAIT, 4, clock cycles spent in SLIP after the rxslip pulse before recounting (>=1)
SLIP_CNT_W, 16, width of each per-lane slip counter

Ports:
i_clk  in  1  core clock, all logic on posedge
i_rst_n  in  1  reset; asynchronous, active-low
i_header  in  2*NUM_LANES  sync header, lane n at [2n+1:2n]
i_header_valid  in  NUM_LANES  lane n header is presented this cycle
i_stat_clr  in  1  synchronous clear of all slip counters
o_block_lock  out  NUM_LANES  per-lane block_lock
o_rxslip  out  NUM_LANES  one-cycle slip request to GT
o_lock_lost  out  NUM_LANES  one-cycle pulse on block_lock 1->0
o_slip_count  out  NUM_LANES*SLIP_CNT_W  per-lane saturating slip count, lane n at [SLIP_CNT_W*(n+1)-1:SLIP_CNT_W*n]
o_all_locked  out  1  registered AND of o_block_lock

Behaviour:
- Reset (async, i_rst_n=0):
  - every lane goes to LOCK_INIT
  - all outputs are 0, all counters are 0
  - assertion mid-operation clears immediately, including a pulse in flight
- sh_valid = header is 2'b01 or 2'b10. A header is evaluated only in a cycle with i_header_valid[n]=1 and the lane in TEST_SH. Headers presented in other states are ignored.
- Counters:
  - sh_cnt and sh_inv are $clog2(SH_CNT_MAX+1) bits wide
  - per evaluated header: nc = sh_cnt+1; ni = sh_inv + !sh_valid
- FSM states: LOCK_INIT, RESET_CNT, TEST_SH, SLIP.
  - LOCK_INIT: block_lock<=0; go to RESET_CNT next cycle.
  - RESET_CNT: one cycle; sh_cnt<=0, sh_inv<=0; go to TEST_SH.
  - TEST_SH, valid header:
    - sh_cnt<=nc
    - if nc==SH_CNT_MAX and ni==0: block_lock<=1, go to RESET_CNT
    - else if nc==SH_CNT_MAX: go to RESET_CNT, block_lock unchanged
  - TEST_SH, invalid header:
    - sh_cnt<=nc, sh_inv<=ni
    - if ni==SH_INVALID_MAX or block_lock==0: go to SLIP (slip has priority over window end)
    - else if nc==SH_CNT_MAX: go to RESET_CNT
  - On entry to SLIP:
    - block_lock<=0
    - o_rxslip=1 for exactly the first SLIP cycle
    - wait counter loaded to SLIP_WAIT-1
  - In SLIP: decrement the wait counter each clock regardless of header_valid; at 0, go to RESET_CNT. Total SLIP dwell = SLIP_WAIT cycles.
- All outputs are registered. block_lock changes on the clock edge after the deciding header. o_rxslip is high in the cycle after the deciding header.
- o_lock_lost[n]: one-cycle pulse, coincident with o_block_lock[n] falling.
- o_slip_count[n]:
  - +1 on each o_rxslip pulse
  - saturates at all-ones
  - i_stat_clr sets it to 0; i_stat_clr and a slip in the same cycle give 1
- o_all_locked: registered AND of o_block_lock, so one cycle behind the per-lane flags.
- Lanes share no state except i_stat_clr and o_all_locked.
- No illegal state reachable; the default branch returns to LOCK_INIT.

Decomposition:
- Package eth_pcs_pkg holds:
  - the bl_fsm_t enum (LOCK_INIT, RESET_CNT, TEST_SH, SLIP)
  - constants SH_DATA=2'b01, SH_CTRL=2'b10
- Sub-module eth_block_sync_lane: one lane's FSM, counters, slip stats and lock_lost pulse.
- The top generates NUM_LANES instances and the all-locked register.

Test Plan:
- Default parameters, release reset, header_valid=1 continuously, all headers 2'b01 → o_block_lock=1 the cycle after the 64th header (3rd cycle of headers begins after LOCK_INIT/RESET_CNT); o_rxslip never asserted; o_slip_count=0.
- Unlocked lane receives 2'b00 as first header → o_rxslip=1 for 1 cycle; 4 SLIP cycles then RESET_CNT; o_slip_count=1. Repeat 3 times → count=3.
- Locked lane, one window with 15 invalid headers → lock held. Next window, 16th invalid header at header index 20 → slip issued immediately; o_block_lock falls with o_lock_lost=1 pulse.
- header_valid toggling 1/0 every cycle with valid headers → lock after 64 qualified headers (~128 cycles); invalid headers on header_valid=0 cycles have no effect.
- SLIP_CNT_W=2, force 5 slips → count saturates at 3. Assert i_stat_clr together with a slip → count=1.
- NUM_LANES=4:
  - lanes 0-3 locked → o_all_locked=1
  - corrupt lane 2 → only lane 2 slips/unlocks; o_all_locked falls one cycle later
  - async reset mid-SLIP → all outputs 0 immediately, relock from LOCK_INIT
